aes128_encrypt_unit: RTL and testbench
======================================

Name: aes128_encrypt_unit

Overview:
Iterative AES-128 encryption engine with an integrated key register and on-the-fly round-key expansion (FIPS-197). A 128-bit key is loaded with a one-cycle pulse. Each start pulse then encrypts one 128-bit block, one round per clock cycle. The block sits behind the accelerator's control/register interface and replaces the separate encryption core and key-expansion pair.

Parameters:
NR, 10, number of AES rounds (AES-128 only; other values unsupported)

Ports:
clk  input  1  system clock; all state updates on rising edge
reset  input  1  synchronous, active-high reset
key_in  input  128  cipher key, byte 0 = bits [127:120]
set_new_key  input  1  load key_in into key register at this edge
plain_text  input  128  plaintext block, byte 0 = bits [127:120]; sampled on accepted start
start  input  1  start-encryption request
cipher_text  output  128  ciphertext of last completed operation, held stable
ready  output  1  high when idle and able to accept start
done  output  1  one-cycle completion pulse

Behaviour:
- One clock domain.
- Reset is synchronous and active-high: with reset=1 at a rising edge, cipher_text=0, done=0, ready=1, key register=0, round counter=0, FSM=IDLE. Reset overrides all other inputs, including mid-operation (the operation is abandoned and no done pulse is generated).
- Byte/column mapping per FIPS-197: bits [127:96] form column 0, with the top byte as row 0.
- Key register: at any edge with set_new_key=1 (and reset=0), key_reg <= key_in. This is independent of FSM state.
- An in-flight operation uses its own working round-key register, so a key load during BUSY does not affect it.
- If start and set_new_key are both accepted at the same edge, the encryption uses the previous key_reg value.
- FSM states:
  - IDLE: ready=1. On start=1: state_reg <= plain_text XOR key_reg; rk_reg <= key_reg; round <= 1; go to BUSY, ready <= 0. start=0 stays IDLE.
  - BUSY: each edge computes next_rk = KeyExpand(rk_reg, Rcon[round]) combinationally, then:
    - round 1..9: state_reg <= MixColumns(ShiftRows(SubBytes(state_reg))) XOR next_rk.
    - round 10: MixColumns is omitted.
    - rk_reg <= next_rk; round <= round+1.
    - On the edge performing round 10: cipher_text <= result; done <= 1; ready <= 1; go to IDLE.
  - start is ignored while BUSY.
- KeyExpand: temp = SubWord(RotWord(w3)) XOR {Rcon,24'h0}; w0' = w0^temp, w1' = w1^w0', w2' = w2^w1', w3' = w3^w2'.
- Rcon sequence: 01,02,04,08,10,20,40,80,1b,36.
- Latency: start accepted at edge T produces done=1 during the cycle following edge T+10, and deasserted at edge T+11 unless it is re-asserted. Back-to-back operations are allowed: a start asserted while done=1 is accepted because ready=1.
- cipher_text changes only at the round-10 edge or on reset. It holds its value after done falls.
- S-box: combinational 256-entry ROM (16 instances for state, 4 for key path) or an equivalent composite-field implementation; result must be bit-exact.
- GF(2^8) xtime uses polynomial 0x11b.

Test Plan:
- Reset, then load key 2b7e151628aed2a6abf7158809cf4f3c; start with PT 3243f6a8885a308d313198a2e0370734 -> done pulses exactly 1 cycle, 11 cycles after start edge; cipher_text = 3925841d02dc09fbdc118597196a0b32, stable after done falls.
- Same key, PT 00112233445566778899aabbccddeeff -> cipher_text = 8df4e9aac5c7573a27d8d055d6e4d64b.
- Load key 000102030405060708090a0b0c0d0e0f, PT 00112233445566778899aabbccddeeff -> cipher_text = 69c4e0d86a7b0430d8cdb78070b4c55a.
- After reset, without loading a key, PT all-zero -> cipher_text = 66e94bd4ef8a2c3b884cfa59ca342b2e.
- During BUSY: pulse start and set_new_key with a different key -> running result unchanged (first vector still correct). The next op uses the new key.
- Assert reset mid-operation -> no done pulse; ready=1, cipher_text=0 at the next cycle; a subsequent full run reproduces the expected vectors.

Source files
------------

// File: rtl/aes128_encrypt_unit.sv
// Iterative AES-128 encryptor: one round per clock, on-the-fly round-key expansion,
// with a key register that can be reloaded at any time without disturbing a running block.

module aes_sbox (
  input  logic [7:0] a,
  output logic [7:0] y
);
  localparam logic [2047:0] ROM = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };
  // Entry 0 sits in the top byte, so entry a starts at bit (255-a)*8 = {~a,000}.
  assign y = ROM[{~a, 3'b000} +: 8];
endmodule

module aes128_encrypt_unit #(
  parameter int NR = 10
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [127:0] key_in,
  input  logic         set_new_key,
  input  logic [127:0] plain_text,
  input  logic         start,
  output logic [127:0] cipher_text,
  output logic         ready,
  output logic         done
);
  localparam int         NUM_COLS = 4;
  localparam logic [3:0] LAST     = 4'(NR);
  localparam logic [0:0] IDLE     = 1'b0;
  localparam logic [0:0] BUSY     = 1'b1;

  logic [0:0]   fsm;
  logic [3:0]   round;
  logic [127:0] key_reg, rk_reg, state_reg;
  logic [127:0] sr_out, mc_out, next_rk;
  logic [31:0]  rot_w, sub_w, temp;
  logic [7:0]   rcon;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] mix_col(input logic [31:0] col);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = col;
    return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
            xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
  endfunction

  always_comb begin
    rcon = 8'h00;
    case (round)
      4'd1:  rcon = 8'h01;
      4'd2:  rcon = 8'h02;
      4'd3:  rcon = 8'h04;
      4'd4:  rcon = 8'h08;
      4'd5:  rcon = 8'h10;
      4'd6:  rcon = 8'h20;
      4'd7:  rcon = 8'h40;
      4'd8:  rcon = 8'h80;
      4'd9:  rcon = 8'h1b;
      4'd10: rcon = 8'h36;
      default: rcon = 8'h00;
    endcase
  end

  // ShiftRows is folded into which state byte feeds each S-box, so sr_out is SubBytes+ShiftRows.
  generate
    for (genvar c = 0; c < NUM_COLS; c++) begin : g_col
      for (genvar r = 0; r < 4; r++) begin : g_row
        aes_sbox u_sbox (
          .a(state_reg[127-8*(r+4*((c+r)%4)) -: 8]),
          .y(sr_out[127-8*(r+4*c) -: 8])
        );
      end
      assign mc_out[127-32*c -: 32] = mix_col(sr_out[127-32*c -: 32]);
    end

    for (genvar b = 0; b < 4; b++) begin : g_key
      aes_sbox u_ksbox (
        .a(rot_w[31-8*b -: 8]),
        .y(sub_w[31-8*b -: 8])
      );
    end
  endgenerate

  assign rot_w = {rk_reg[23:0], rk_reg[31:24]};
  assign temp  = sub_w ^ {rcon, 24'h0};

  always_comb begin
    next_rk          = '0;
    next_rk[127:96]  = rk_reg[127:96] ^ temp;
    next_rk[95:64]   = rk_reg[95:64]  ^ next_rk[127:96];
    next_rk[63:32]   = rk_reg[63:32]  ^ next_rk[95:64];
    next_rk[31:0]    = rk_reg[31:0]   ^ next_rk[63:32];
  end

  assign ready = (fsm == IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      fsm         <= IDLE;
      round       <= '0;
      key_reg     <= '0;
      rk_reg      <= '0;
      state_reg   <= '0;
      cipher_text <= '0;
      done        <= 1'b0;
    end else begin
      done <= 1'b0;
      if (set_new_key) key_reg <= key_in;
      case (fsm)
        IDLE: begin
          // key_reg here is the pre-load value even if set_new_key is also high.
          if (start) begin
            state_reg <= plain_text ^ key_reg;
            rk_reg    <= key_reg;
            round     <= 4'd1;
            fsm       <= BUSY;
          end
        end
        BUSY: begin
          rk_reg <= next_rk;
          round  <= round + 4'd1;
          if (round == LAST) begin
            cipher_text <= sr_out ^ next_rk;
            state_reg   <= sr_out ^ next_rk;
            done        <= 1'b1;
            fsm         <= IDLE;
          end else begin
            state_reg <= mc_out ^ next_rk;
          end
        end
        default: fsm <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_aes128_encrypt_unit.sv
// Scoreboard bench for aes128_encrypt_unit: a FIPS-197 reference model built from GF(2^8)
// arithmetic feeds an expected-value queue that a negedge monitor drains on each done pulse.

module tb_aes128_encrypt_unit;
  logic         clk = 1'b0;
  logic         reset;
  logic [127:0] key_in;
  logic         set_new_key;
  logic [127:0] plain_text;
  logic         start;
  logic [127:0] cipher_text;
  logic         ready;
  logic         done;

  int total = 0;
  int bad   = 0;
  logic [127:0] exp_q[$];
  logic [127:0] model_key;
  logic [7:0]   sbox_tab[256];

  localparam logic [127:0] K_FIPS = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] K_SEQ  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] PT_A   = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] PT_B   = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT_AA  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] CT_AB  = 128'h8df4e9aac5c7573a27d8d055d6e4d64b;
  localparam logic [127:0] CT_SB  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] CT_00  = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

  aes128_encrypt_unit #(.NR(10)) dut (
    .clk(clk), .reset(reset), .key_in(key_in), .set_new_key(set_new_key),
    .plain_text(plain_text), .start(start), .cipher_text(cipher_text),
    .ready(ready), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h", name, act, want);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= x;
      x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    logic [7:0] r = b;
    for (int i = 0; i < n; i++) r = {r[6:0], r[7]};
    return r;
  endfunction

  task automatic build_sbox();
    for (int x = 0; x < 256; x++) begin
      logic [7:0] inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (x != 0 && gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sbox_tab[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [127:0] aes_ref(input logic [127:0] key, input logic [127:0] pt);
    logic [31:0]  w[44];
    logic [7:0]   s[16];
    logic [7:0]   t[16];
    logic [7:0]   rc = 8'h01;
    logic [31:0]  tmp;
    logic [127:0] res;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {tmp[23:0], tmp[31:24]};
        tmp = {sbox_tab[tmp[31:24]], sbox_tab[tmp[23:16]], sbox_tab[tmp[15:8]], sbox_tab[tmp[7:0]]};
        tmp ^= {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ w[i/4][31-8*(i%4) -: 8];
    for (int r = 1; r <= 10; r++) begin
      for (int i = 0; i < 16; i++) t[i] = sbox_tab[s[i]];
      for (int c = 0; c < 4; c++)
        for (int row = 0; row < 4; row++) s[row+4*c] = t[row+4*((c+row)%4)];
      if (r < 10)
        for (int c = 0; c < 4; c++) begin
          logic [7:0] a0, a1, a2, a3;
          a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
          s[4*c]   = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
          s[4*c+1] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
          s[4*c+2] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
          s[4*c+3] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
        end
      for (int i = 0; i < 16; i++) s[i] ^= w[4*r+i/4][31-8*(i%4) -: 8];
    end
    for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
    return res;
  endfunction

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (reset === 1'b0 && done === 1'b1) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_done got=%h want=none", cipher_text);
      end else begin
        check("cipher", cipher_text, exp_q.pop_front());
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic load_key(input logic [127:0] k);
    @(negedge clk);
    key_in = k;
    set_new_key = 1'b1;
    @(posedge clk);
    #1 set_new_key = 1'b0;
    model_key = k;
  endtask

  // One operation; optionally loads ldk on the start edge or injects start+key mid-flight.
  task automatic do_op(input logic [127:0] pt, input logic [127:0] exp,
                       input bit ld_start, input logic [127:0] ldk,
                       input bit inj_busy, input logic [127:0] injk);
    int n = 0;
    @(negedge clk);
    check("ready_idle", 128'(ready), 128'(1));
    plain_text = pt;
    start = 1'b1;
    if (ld_start) begin key_in = ldk; set_new_key = 1'b1; end
    exp_q.push_back(exp);
    @(posedge clk);
    #1;
    start = 1'b0;
    set_new_key = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin n = i; break; end
      if (inj_busy && i == 4) begin
        key_in = injk; set_new_key = 1'b1; start = 1'b1;
        plain_text = ~pt;
      end else begin
        set_new_key = 1'b0; start = 1'b0;
      end
    end
    start = 1'b0;
    set_new_key = 1'b0;
    check("latency", 128'(n), 128'(11));
    @(negedge clk);
    check("done_pulse", 128'(done), 128'(0));
    check("ct_hold", cipher_text, exp);
  endtask

  task automatic do_b2b(input logic [127:0] pt1, input logic [127:0] exp1,
                        input logic [127:0] pt2, input logic [127:0] exp2);
    int n = 0;
    @(negedge clk);
    plain_text = pt1; start = 1'b1;
    exp_q.push_back(exp1);
    @(posedge clk);
    #1 start = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin n = i; break; end
    end
    check("b2b_lat1", 128'(n), 128'(11));
    check("b2b_ready", 128'(ready), 128'(1));
    plain_text = pt2; start = 1'b1;
    exp_q.push_back(exp2);
    @(posedge clk);
    #1 start = 1'b0;
    n = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin n = i; break; end
    end
    check("b2b_lat2", 128'(n), 128'(11));
  endtask

  task automatic abort_op(input logic [127:0] pt);
    @(negedge clk);
    plain_text = pt; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (5) @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    model_key = '0;
    @(negedge clk);
    check("abort_ready", 128'(ready), 128'(1));
    check("abort_ct", cipher_text, 128'(0));
    check("abort_done", 128'(done), 128'(0));
    repeat (12) @(negedge clk);
  endtask

  initial begin
    reset = 1'b1; key_in = '0; set_new_key = 1'b0; plain_text = '0; start = 1'b0;
    model_key = '0;
    build_sbox();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_ready", 128'(ready), 128'(1));
    check("rst_done", 128'(done), 128'(0));
    check("rst_ct", cipher_text, 128'(0));
    reset = 1'b0;

    do_op('0, CT_00, 0, '0, 0, '0);
    load_key(K_FIPS);
    do_op(PT_A, CT_AA, 0, '0, 0, '0);
    do_op(PT_B, CT_AB, 0, '0, 0, '0);
    load_key(K_SEQ);
    do_op(PT_B, CT_SB, 0, '0, 0, '0);

    // mid-flight key load + start must not disturb the running block
    do_op(PT_B, CT_SB, 0, '0, 1, K_FIPS);
    model_key = K_FIPS;
    do_op(PT_A, CT_AA, 0, '0, 0, '0);

    // start and key load on the same idle edge: old key encrypts
    do_op(PT_A, CT_AA, 1, K_SEQ, 0, '0);
    model_key = K_SEQ;
    do_op(PT_B, CT_SB, 0, '0, 0, '0);

    begin
      logic [127:0] pt2;
      pt2 = {$urandom, $urandom, $urandom, $urandom};
      do_b2b(PT_B, CT_SB, pt2, aes_ref(model_key, pt2));
    end
    repeat (2) @(negedge clk);

    abort_op(PT_A);
    do_op('0, CT_00, 0, '0, 0, '0);
    load_key(K_FIPS);
    do_op(PT_A, CT_AA, 0, '0, 0, '0);

    for (int i = 0; i < 12; i++) begin
      logic [127:0] pt;
      if ($urandom_range(0, 2) == 0) load_key({$urandom, $urandom, $urandom, $urandom});
      pt = {$urandom, $urandom, $urandom, $urandom};
      do_op(pt, aes_ref(model_key, pt), 0, '0, 0, '0);
    end

    repeat (3) @(negedge clk);
    check("queue_empty", 128'(exp_q.size()), 128'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
